mc_control: RTL and testbench

MC_CONTROL -- requirements
Module: mc_control

---
 rtl/mc_control_pkg.sv | 42 ++++
 rtl/mc_control_outputs.sv | 82 ++++++++
 rtl/mc_control.sv | 79 +++++++
 tb/tb_mc_control.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mc_control_pkg.sv
// rtl/mc_control_pkg.sv - state, opcode and datapath-select encodings for the multicycle controller
package mc_control_pkg;

    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_EXEC_R   = 4'd2;
    localparam logic [3:0] ST_EXEC_I   = 4'd3;
    localparam logic [3:0] ST_MEM_ADDR = 4'd4;
    localparam logic [3:0] ST_MEM_RD   = 4'd5;
    localparam logic [3:0] ST_MEM_WR   = 4'd6;
    localparam logic [3:0] ST_WB_ALU   = 4'd7;
    localparam logic [3:0] ST_WB_MEM   = 4'd8;
    localparam logic [3:0] ST_BRANCH   = 4'd9;
    localparam logic [3:0] ST_JUMP     = 4'd10;
    localparam logic [3:0] ST_TRAP     = 4'd11;

    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_I_TYPE = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_RS1    = 2'b01;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b10;

    localparam logic [1:0] SRC_B_RS2    = 2'b00;
    localparam logic [1:0] SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;

    localparam logic [1:0] ALU_ADD      = 2'b00;
    localparam logic [1:0] ALU_SUB      = 2'b01;
    localparam logic [1:0] ALU_R_FUNCT  = 2'b10;
    localparam logic [1:0] ALU_I_FUNCT  = 2'b11;

    localparam logic [1:0] PC_SRC_ALU     = 2'b00;
    localparam logic [1:0] PC_SRC_ALU_REG = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP    = 2'b10;

endpackage

// File: rtl/mc_control_outputs.sv
// rtl/mc_control_outputs.sv - Moore output decode: current state to control bundle
module mc_control_outputs
    import mc_control_pkg::*;
(
    input  logic [3:0] state,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       illegal,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src
);

    always_comb begin
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        illegal       = 1'b0;
        alu_src_a     = SRC_A_PC;
        alu_src_b     = SRC_B_RS2;
        alu_op        = ALU_ADD;
        pc_src        = PC_SRC_ALU;
        case (state)
            // ir_write/pc_write are qualified by mem_ready in the datapath
            ST_FETCH: begin
                mem_read  = 1'b1;
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                alu_src_b = SRC_B_FOUR;
            end
            ST_DECODE: begin
                alu_src_a = SRC_A_OLD_PC;
                alu_src_b = SRC_B_IMM;
            end
            ST_EXEC_R: begin
                alu_src_a = SRC_A_RS1;
                alu_op    = ALU_R_FUNCT;
            end
            ST_EXEC_I: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                alu_op    = ALU_I_FUNCT;
            end
            ST_MEM_ADDR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
            end
            ST_MEM_RD: mem_read  = 1'b1;
            ST_MEM_WR: mem_write = 1'b1;
            ST_WB_ALU: reg_write = 1'b1;
            ST_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a     = SRC_A_RS1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_src        = PC_SRC_ALU_REG;
            end
            // PC already holds old PC+4 from FETCH, which is the link value
            ST_JUMP: begin
                reg_write = 1'b1;
                pc_write  = 1'b1;
                pc_src    = PC_SRC_JUMP;
            end
            ST_TRAP: illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// rtl/mc_control.sv - multicycle controller: state register and next-state logic
module mc_control
    import mc_control_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       illegal,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic [3:0] state
);

    logic [3:0] state_q;
    logic [3:0] state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:    if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    OP_R_TYPE:         state_d = ST_EXEC_R;
                    OP_I_TYPE:         state_d = ST_EXEC_I;
                    OP_LOAD, OP_STORE: state_d = ST_MEM_ADDR;
                    OP_BRANCH:         state_d = ST_BRANCH;
                    OP_JAL, OP_JALR:   state_d = ST_JUMP;
                    default:           state_d = ST_TRAP;
                endcase
            end
            ST_EXEC_R:   state_d = ST_WB_ALU;
            ST_EXEC_I:   state_d = ST_WB_ALU;
            ST_MEM_ADDR: state_d = (opcode == OP_LOAD) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:   if (mem_ready) state_d = ST_WB_MEM;
            ST_MEM_WR:   if (mem_ready) state_d = ST_FETCH;
            ST_WB_ALU:   state_d = ST_FETCH;
            ST_WB_MEM:   state_d = ST_FETCH;
            ST_BRANCH:   state_d = ST_FETCH;
            ST_JUMP:     state_d = ST_FETCH;
            ST_TRAP:     state_d = ST_TRAP;
            // unreachable encodings are treated as a fault
            default:     state_d = ST_TRAP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_FETCH;
        else       state_q <= state_d;
    end

    assign state = state_q;

    mc_control_outputs u_outputs (
        .state         (state_q),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .reg_write     (reg_write),
        .mem_to_reg    (mem_to_reg),
        .illegal       (illegal),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_src        (pc_src)
    );

endmodule

// File: tb/tb_mc_control.sv
// tb/tb_mc_control.sv - directed scoreboard bench for mc_control
module tb_mc_control;
    import mc_control_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       ir_write, pc_write, pc_write_cond, mem_read, mem_write;
    logic       reg_write, mem_to_reg, illegal;
    logic [1:0] alu_src_a, alu_src_b, alu_op, pc_src;
    logic [3:0] state;

    int checks   = 0;
    int failures = 0;

    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    mc_control dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .reg_write     (reg_write),
        .mem_to_reg    (mem_to_reg),
        .illegal       (illegal),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_src        (pc_src),
        .state         (state)
    );

    // {ir_write,pc_write,pc_write_cond,mem_read,mem_write,reg_write,mem_to_reg,illegal,
    //  alu_src_a,alu_src_b,alu_op,pc_src}
    function automatic logic [15:0] exp_out(input logic [3:0] st);
        case (st)
            ST_FETCH:    return 16'b1101_0000_0001_0000;
            ST_DECODE:   return 16'b0000_0000_1010_0000;
            ST_EXEC_R:   return 16'b0000_0000_0100_1000;
            ST_EXEC_I:   return 16'b0000_0000_0110_1100;
            ST_MEM_ADDR: return 16'b0000_0000_0110_0000;
            ST_MEM_RD:   return 16'b0001_0000_0000_0000;
            ST_MEM_WR:   return 16'b0000_1000_0000_0000;
            ST_WB_ALU:   return 16'b0000_0100_0000_0000;
            ST_WB_MEM:   return 16'b0000_0110_0000_0000;
            ST_BRANCH:   return 16'b0010_0000_0100_0101;
            ST_JUMP:     return 16'b0100_0100_0000_0010;
            ST_TRAP:     return 16'b0000_0001_0000_0000;
            default:     return 16'hxxxx;
        endcase
    endfunction

    // Drive one cycle's inputs, record the state expected after the edge, then check it
    task automatic cyc(input logic rdy, input logic rst, input logic [3:0] exp_st, input string tag);
        logic [3:0]  e;
        logic [15:0] obs, exp_o;
        mem_ready = rdy;
        reset     = rst;
        exp_q.push_back(exp_st);
        @(posedge clk);
        #1;
        e     = exp_q.pop_front();
        obs   = {ir_write, pc_write, pc_write_cond, mem_read, mem_write, reg_write, mem_to_reg,
                 illegal, alu_src_a, alu_src_b, alu_op, pc_src};
        exp_o = exp_out(e);
        checks++;
        assert (state === e) else begin
            failures++;
            $error("FAIL %s state observed=%0d expected=%0d", tag, state, e);
        end
        checks++;
        assert (obs === exp_o) else begin
            failures++;
            $error("FAIL %s outputs observed=%b expected=%b", tag, obs, exp_o);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; mem_ready = 1'b0; opcode = 7'b0110011;
        cyc(0, 1, ST_FETCH, "reset0");
        cyc(1, 1, ST_FETCH, "reset1");

        // R-type, with a fetch stall first
        cyc(0, 0, ST_FETCH,  "r_stall");
        cyc(1, 0, ST_DECODE, "r_dec");
        cyc(1, 0, ST_EXEC_R, "r_exec");
        cyc(1, 0, ST_WB_ALU, "r_wb");
        cyc(1, 0, ST_FETCH,  "r_fetch");

        opcode = 7'b0010011;
        cyc(1, 0, ST_DECODE, "i_dec");
        cyc(1, 0, ST_EXEC_I, "i_exec");
        cyc(1, 0, ST_WB_ALU, "i_wb");
        cyc(1, 0, ST_FETCH,  "i_fetch");

        // LW with three wait cycles in MEM_RD
        opcode = 7'b0000011;
        cyc(1, 0, ST_DECODE,   "lw_dec");
        cyc(1, 0, ST_MEM_ADDR, "lw_addr");
        cyc(1, 0, ST_MEM_RD,   "lw_rd1");
        cyc(0, 0, ST_MEM_RD,   "lw_rd2");
        cyc(0, 0, ST_MEM_RD,   "lw_rd3");
        cyc(0, 0, ST_MEM_RD,   "lw_rd4");
        cyc(1, 0, ST_WB_MEM,   "lw_wb");
        cyc(1, 0, ST_FETCH,    "lw_fetch");

        opcode = 7'b0100011;
        cyc(1, 0, ST_DECODE,   "sw_dec");
        cyc(1, 0, ST_MEM_ADDR, "sw_addr");
        cyc(1, 0, ST_MEM_WR,   "sw_wr");
        cyc(1, 0, ST_FETCH,    "sw_fetch");

        opcode = 7'b1100011;
        cyc(1, 0, ST_DECODE, "beq_dec");
        cyc(1, 0, ST_BRANCH, "beq_br");
        cyc(1, 0, ST_FETCH,  "beq_fetch");

        opcode = 7'b1101111;
        cyc(1, 0, ST_DECODE, "jal_dec");
        cyc(1, 0, ST_JUMP,   "jal_jump");
        cyc(1, 0, ST_FETCH,  "jal_fetch");

        opcode = 7'b1100111;
        cyc(1, 0, ST_DECODE, "jalr_dec");
        cyc(1, 0, ST_JUMP,   "jalr_jump");
        cyc(1, 0, ST_FETCH,  "jalr_fetch");

        // Illegal opcode: TRAP holds regardless of mem_ready until reset
        opcode = 7'b1111111;
        cyc(1, 0, ST_DECODE, "trap_dec");
        for (int i = 0; i < 10; i++) cyc(i[0], 0, ST_TRAP, "trap_hold");
        cyc(0, 1, ST_FETCH,  "trap_reset");
        cyc(0, 0, ST_FETCH,  "trap_after");

        opcode = 7'b0000000;
        cyc(1, 0, ST_DECODE, "op0_dec");
        cyc(1, 0, ST_TRAP,   "op0_trap");
        cyc(1, 1, ST_FETCH,  "op0_reset");

        // Reset while stalled in MEM_RD
        opcode = 7'b0000011;
        cyc(1, 0, ST_DECODE,   "rrd_dec");
        cyc(1, 0, ST_MEM_ADDR, "rrd_addr");
        cyc(0, 0, ST_MEM_RD,   "rrd_rd1");
        cyc(0, 0, ST_MEM_RD,   "rrd_rd2");
        cyc(0, 1, ST_FETCH,    "rrd_reset");
        cyc(0, 0, ST_FETCH,    "rrd_fetch");

        // Reset while stalled in MEM_WR
        opcode = 7'b0100011;
        cyc(1, 0, ST_DECODE,   "rwr_dec");
        cyc(1, 0, ST_MEM_ADDR, "rwr_addr");
        cyc(0, 0, ST_MEM_WR,   "rwr_wr1");
        cyc(0, 0, ST_MEM_WR,   "rwr_wr2");
        cyc(0, 1, ST_FETCH,    "rwr_reset");

        checks++;
        assert (exp_q.size() == 0) else begin
            failures++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
